// File: rtl/adder_bist.sv
// Built-in self-test controller for WIDTH-bit combinational adders: drives corner
// and LFSR vectors, checks {cout,s} against a golden sum, reports error stats.
module adder_bist #(
  parameter int          WIDTH       = 32,
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_1234
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      vec_count,
  output logic [15:0]      fail_index,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] NO_FAIL  = 16'hFFFF;

  // Alternating pattern with the MSB set; its complement forms the other operand.
  function automatic logic [WIDTH-1:0] alt_pat();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = (((WIDTH - 1 - i) % 2) == 0);
    return r;
  endfunction
  localparam logic [WIDTH-1:0] ALT = alt_pat();

  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
  endfunction

  state_e           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [15:0]      err_count_q, err_count_d;
  logic [15:0]      vec_count_q, vec_count_d;
  logic [15:0]      fail_index_q, fail_index_d;
  logic [WIDTH-1:0] dut_a_q, dut_a_d, dut_b_q, dut_b_d;
  logic             dut_cin_q, dut_cin_d;
  logic [31:0]      lfsr_q, lfsr_d;

  logic [15:0]      sel_idx;
  logic [WIDTH-1:0] va, vb;
  logic             vc;
  logic [31:0]      swap;
  logic [WIDTH:0]   golden;
  logic             mismatch;

  assign golden   = {1'b0, dut_a_q} + {1'b0, dut_b_q} + {{WIDTH{1'b0}}, dut_cin_q};
  assign mismatch = ({dut_cout, dut_s} != golden);
  assign swap     = {lfsr_q[15:0], lfsr_q[31:16]};

  // Vector generator: corners by index, then the LFSR state held for the next random vector.
  always_comb begin
    va = '0;
    vb = '0;
    vc = 1'b0;
    case (sel_idx)
      16'd0: begin va = '0;           vb = '0;           vc = 1'b0; end
      16'd1: begin va = WIDTH'(1);    vb = WIDTH'(1);    vc = 1'b0; end
      16'd2: begin va = '1;           vb = WIDTH'(1);    vc = 1'b0; end
      16'd3: begin va = ALT;          vb = ~ALT;         vc = 1'b1; end
      16'd4: begin va = '1;           vb = '1;           vc = 1'b1; end
      default: begin
        va = lfsr_q[WIDTH-1:0];
        vb = swap[WIDTH-1:0];
        vc = lfsr_q[31];
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    err_count_d  = err_count_q;
    vec_count_d  = vec_count_q;
    fail_index_d = fail_index_q;
    dut_a_d      = dut_a_q;
    dut_b_d      = dut_b_q;
    dut_cin_d    = dut_cin_q;
    lfsr_d       = lfsr_q;
    sel_idx      = vec_count_q + 16'd1;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          sel_idx      = 16'd0;
          dut_a_d      = va;
          dut_b_d      = vb;
          dut_cin_d    = vc;
          lfsr_d       = SEED_EFF;
          err_count_d  = '0;
          vec_count_d  = '0;
          fail_index_d = NO_FAIL;
        end
      end
      RUN: begin
        vec_count_d = vec_count_q + 16'd1;
        if (mismatch) begin
          if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          if (err_count_q == 16'd0)    fail_index_d = vec_count_q;
        end
        if (vec_count_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          dut_a_d   = va;
          dut_b_d   = vb;
          dut_cin_d = vc;
          if (sel_idx >= 16'd5) lfsr_d = lfsr_step(lfsr_q);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_count_q  <= '0;
      vec_count_q  <= '0;
      fail_index_q <= NO_FAIL;
      dut_a_q      <= '0;
      dut_b_q      <= '0;
      dut_cin_q    <= 1'b0;
      lfsr_q       <= SEED_EFF;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_count_q  <= err_count_d;
      vec_count_q  <= vec_count_d;
      fail_index_q <= fail_index_d;
      dut_a_q      <= dut_a_d;
      dut_b_q      <= dut_b_d;
      dut_cin_q    <= dut_cin_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_count_q == 16'd0);
  assign err_count  = err_count_q;
  assign vec_count  = vec_count_q;
  assign fail_index = fail_index_q;
  assign dut_a      = dut_a_q;
  assign dut_b      = dut_b_q;
  assign dut_cin    = dut_cin_q;

endmodule

// File: doc/adder_bist.md
# adder_bist

Built-in self-test controller for the team's combinational `WIDTH`-bit adders (prefix, ripple, carry-select) that share the operand/carry-in → sum/carry-out interface. It sits on the operand side of that interface and drives `a`, `b` and `cin` into the adder under test. It reads back `s` and `cout` and compares them against a behavioural golden sum. Each run applies a fixed corner-case sequence followed by pseudo-random vectors, then reports pass/fail, an error count and the index of the first failing vector.

## Interface
Parameters:
- `WIDTH`, 32, adder operand width; legal range 8..32.
- `NUM_VECTORS`, 256, total vectors per run, corners included; legal range 5..65535.
- `SEED`, 32'hACE1_1234, LFSR seed; a value of 0 is replaced by 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, sampled on `clk`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`=1; high when `err_count`==0.
- `err_count`  out  16  number of mismatching vectors; saturates at 16'hFFFF.
- `vec_count`  out  16  number of vectors compared so far in this run.
- `fail_index`  out  16  index of the first failing vector; 16'hFFFF if none.
- `dut_a`, `dut_b`  out  `WIDTH`  registered operands.
- `dut_cin`  out  1  registered carry-in.
- `dut_s`  in  `WIDTH`  adder sum.
- `dut_cout`  in  1  adder carry-out.

## Operation
- FSM states: IDLE, RUN, DONE. Reset (asynchronous, any state) → IDLE.
  - Reset values: all outputs 0, except `fail_index`=16'hFFFF.
- IDLE, `start`=1: load vector 0 onto the `dut_*` registers, load the LFSR with `SEED`, clear all counters and set `fail_index`=16'hFFFF → RUN.
- RUN, every cycle:
  - Compare `{dut_cout,dut_s}` with the `WIDTH+1`-bit sum `dut_a + dut_b + dut_cin`.
  - On mismatch, increment `err_count` (saturating). If this is the first failure, set `fail_index` to the current vector index.
  - Increment `vec_count`.
  - Drive the next vector. After vector `NUM_VECTORS-1` has been compared → DONE.
- `start` is ignored in RUN.
- DONE: counters and `dut_*` hold their values; `start`=1 behaves as in IDLE, clearing and restarting → RUN.
- Vector sequence:
  - 0: a=0, b=0, cin=0.
  - 1: a=1, b=1, cin=0.
  - 2: a=all-ones, b=1, cin=0.
  - 3: a=1010…, b=0101…, cin=1 (full-length carry propagate).
  - 4: a=all-ones, b=all-ones, cin=1.
  - 5 onward: pseudo-random, derived from the 32-bit Galois LFSR `q` (tap mask 32'h8020_0003, right shift, apply mask when the shifted-out bit is 1):
    - a = q[WIDTH-1:0].
    - b = {q[15:0],q[31:16]}[WIDTH-1:0].
    - cin = q[31].
    - Vector 5 uses `q`=`SEED`. The LFSR advances once per random vector.
- The DUT is purely combinational. The compare is combinational from the `dut_*` registers through the DUT, and the result is registered at the next edge.

## Timing
- Edge T0, with `start`=1 in IDLE/DONE:
  - After T0: `busy`=1, `done`=0, `dut_*` = vector 0.
- Vector i is valid between edges Ti and Ti+1 and is compared at edge Ti+1.
- Edge TN (N=`NUM_VECTORS`):
  - `busy`=0, `done`=1.
  - `vec_count`=N; `err_count`, `fail_index` and `pass` are final.
- Run length: exactly N cycles from `start` to `done`.
- `pass` is combinational from `done` and `err_count`; it is 0 whenever `done`=0.
- `start` held high in DONE: a new run starts at the next edge, and `done` drops.
- Reset mid-RUN: immediate return to IDLE. Outputs take their reset values with no `clk` edge required.
- The combinational path `dut_*` → DUT → compare → counters must meet timing in a single cycle.

## Test plan
- Correct 32-bit prefix adder, `NUM_VECTORS`=16, pulse `start` → `done` exactly 16 cycles later; `pass`=1, `err_count`=0, `vec_count`=16, `fail_index`=16'hFFFF.
- DUT with `cout` stuck at 0 → vectors 2, 3, 4 fail; `fail_index`=2, `pass`=0.
  - Any random vector producing a true carry-out also counts as an error.
- DUT with `s[0]` stuck at 0 → first failure at vector 4 (expected 1_FFFF_FFFF), so `fail_index`=4.
- Check the first random vector: after the edge at which vector 4 is compared, `dut_a`=32'hACE1_1234, `dut_b`=32'h1234_ACE1, `dut_cin`=1.
- `start` pulsed during RUN is ignored; drop `rst_n` at cycle 7 of a run → asynchronous return to IDLE with `busy`=0, `vec_count`=0 and `dut_*`=0.
- From DONE, pulse `start` → counters clear, and the sequence replays identically.
  - Same `dut_*` trace; final counts identical to the previous run.
